rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Round-robin arbiter sharing one resource among N requesters. Built around a lowest-set-bit priority encoder.
- Grants are registered, one-hot and held until the grantee drops its request.
- A rotating pointer gives starvation-free fairness.
- Sits in front of any shared datapath, e.g. a bus port or a shared ALU.

Parameters:
- N, 4, number of requesters; legal range 2..32.
- HOLD_MAX, 16, maximum consecutive grant cycles for one requester. Used only when ARB_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N  request vector; bit i high means requester i wants the resource
- gnt  out  N  one-hot grant vector, registered
- gnt_valid  out  1  high when any grant is active; equals |gnt
- gnt_id  out  $clog2(N)  binary index of the grantee; 0 when gnt_valid=0
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (async, rst_n=0): gnt=0, gnt_valid=0, gnt_id=0, timeout=0, ptr=0, state=IDLE, hold counter=0, blocked mask=0. Outputs clear immediately, without waiting for a clock edge.
- A reset assertion mid-grant drops the grant at once. After rst_n deasserts, the first evaluation happens at the next rising edge.
- Winner selection (combinational):
  - masked = eligible & {bits >= ptr}.
  - winner = lowest set bit of masked if masked != 0, else lowest set bit of eligible.
  - eligible = req & ~blocked.
- State IDLE:
  - If eligible != 0 at an edge: next cycle state=GRANT, gnt=onehot(winner), gnt_id=winner, ptr=(winner+1) mod N. Request-to-grant latency is 1 cycle.
  - Otherwise stay in IDLE.
- State GRANT:
  - While req[gnt_id]=1 (and no timeout), hold gnt unchanged; ptr is frozen.
  - Release: when req[gnt_id]=0 is sampled, re-evaluate the winner in the same edge, excluding gnt_id.
    - If another eligible requester exists, grant it on the next cycle with no idle bubble (back-to-back handover) and update ptr.
    - Otherwise go to IDLE with gnt=0.
- Pointer wrap: granting N-1 sets ptr=0.
- Requests that change while a grant is held only affect the next selection.
- Invariant: gnt is never more than one-hot.
- A req bit asserting and dropping within one cycle while another requester holds the grant is simply missed; no request latching.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A hold counter starts at 1 on each new grant and increments each held cycle.
  - On the edge where the counter equals HOLD_MAX and req[gnt_id] is still 1, the grant is revoked.
  - At that edge: timeout=1 for the following cycle, the blocked bit for gnt_id is set, and the next eligible winner is granted back-to-back (or the block enters IDLE).
  - A blocked bit clears at the first edge where its req bit is sampled 0.
  - Net effect: the grantee holds gnt for exactly HOLD_MAX cycles.
- Without the macro: no counter and no blocked mask (blocked=0); timeout is constant 0; grants are held indefinitely.

Decomposition:
- Package arb_pkg:
  - state encoding ARB_IDLE=1'b0, ARB_GRANT=1'b1
  - onehot-from-index function
  - localparam for index width, $clog2(N)
- Sub-module lsb_first_encoder:
  - parameter N; inputs vec[N-1:0]; outputs idx[$clog2(N)-1:0] and any_set.
  - Lowest set bit wins.
  - Instantiated twice: once on the masked vector, once on the eligible vector.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 -> gnt=0, gnt_valid=0, gnt_id=0. Release reset; one edge later -> gnt=4'b0001, gnt_id=0.
- Rotation: req=4'b1111, each grantee drops its bit for 1 cycle after 2 grant cycles, then re-raises -> grant order 0,1,2,3,0,1 with no gaps.
- Back-to-back handover: gnt=4'b0010, req goes 4'b0110 -> 4'b0100 -> next cycle gnt=4'b0100; gnt_valid never 0.
- Wrap and fallback: after granting 2 (ptr=3), req=4'b0001 -> gnt=4'b0001, ptr=1. Then req=4'b1001 after release -> gnt=4'b1000.
- Async reset mid-grant: gnt=4'b0100, rst_n pulses low between edges -> gnt=0 immediately. After release with req=4'b0100 -> regranted 1 cycle later, ptr restarted at 0.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=8): req[1] stuck high, req[3] high -> gnt=4'b0010 for exactly 8 cycles, then gnt=4'b1000 with timeout=1 for one cycle. Requester 1 is not regranted until req[1] has been sampled 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Optional hold-timeout feature is enabled by defining ARB_TIMEOUT_EN.
package arb_pkg;

  // Upper bound on requester count supported by the helpers below.
  localparam int ARB_MAX_N = 32;

  // Index width for the default configuration.
  localparam int ARB_N_DEFAULT     = 4;
  localparam int ARB_IDX_W_DEFAULT = $clog2(ARB_N_DEFAULT);

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // One-hot vector with only bit idx set; callers size-cast to their width.
  function automatic logic [ARB_MAX_N-1:0] arb_onehot(input logic [31:0] idx);
    logic [ARB_MAX_N-1:0] v;
    v = '0;
    v[idx[4:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/lsb_first_encoder.sv
// Priority encoder: reports the index of the lowest set bit of vec.
module lsb_first_encoder #(
  parameter int N = 4
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any_set
);

  localparam int IW = $clog2(N);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx     = '0;
    any_set = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grants held until release.
// Define ARB_TIMEOUT_EN to revoke a grant after HOLD_MAX consecutive cycles.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > ARB_MAX_N) begin : g_bad_n
    $error("rr_grant_arbiter: N out of range 2..32");
  end
  if (HOLD_MAX < 2 || HOLD_MAX > 65535) begin : g_bad_hold
    $error("rr_grant_arbiter: HOLD_MAX out of range 2..65535");
  end

  arb_state_e    state_q;
  logic [N-1:0]  gnt_q;
  logic [IW-1:0] gnt_id_q;
  logic [IW-1:0] ptr_q;

  logic [N-1:0]  blocked;
  logic [N-1:0]  excl;
  logic [N-1:0]  eligible;
  logic [N-1:0]  masked;
  logic [N-1:0]  win_oh;
  logic [IW-1:0] m_idx;
  logic [IW-1:0] e_idx;
  logic [IW-1:0] winner;
  logic [IW-1:0] ptr_next;
  logic          m_any;
  logic          e_any;
  logic          held;
  logic          fire;
  logic          keep;
  logic          grant_new;

`ifdef ARB_TIMEOUT_EN
  logic [15:0]   hold_q;
  logic [N-1:0]  blocked_q;
  logic          timeout_q;
`endif

  lsb_first_encoder #(.N(N)) u_enc_masked (
    .vec     (masked),
    .idx     (m_idx),
    .any_set (m_any)
  );

  lsb_first_encoder #(.N(N)) u_enc_elig (
    .vec     (eligible),
    .idx     (e_idx),
    .any_set (e_any)
  );

  // Winner selection: masked search from ptr, falling back to the full set.
  always_comb begin
    held = req[gnt_id_q];
    fire = 1'b0;
    excl = '0;
`ifdef ARB_TIMEOUT_EN
    blocked = blocked_q;
    fire    = (state_q == ARB_GRANT) && held && (hold_q == 16'(HOLD_MAX));
    if (fire) excl = N'(arb_onehot(32'(gnt_id_q)));
`else
    blocked = '0;
`endif
    eligible  = req & ~blocked & ~excl;
    masked    = eligible & ({N{1'b1}} << ptr_q);
    winner    = m_any ? m_idx : e_idx;
    win_oh    = N'(arb_onehot(32'(winner)));
    ptr_next  = (winner == IW'(N - 1)) ? '0 : winner + IW'(1);
    keep      = (state_q == ARB_GRANT) && held && !fire;
    grant_new = !keep && e_any;
  end

  // Grant FSM: state, grant vector, grantee index and rotating pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
    end else if (grant_new) begin
      state_q  <= ARB_GRANT;
      gnt_q    <= win_oh;
      gnt_id_q <= winner;
      ptr_q    <= ptr_next;
    end else if (!keep) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter, timeout pulse and blocked mask for forcibly revoked grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      blocked_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= fire;
      blocked_q <= (blocked_q & req) | excl;
      if (grant_new)  hold_q <= 16'd1;
      else if (keep)  hold_q <= hold_q + 16'd1;
      else            hold_q <= '0;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed scoreboard bench for rr_grant_arbiter (N=4, HOLD_MAX=8).
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b1111;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         c;
    logic [3:0] g;
    logic       to;
  } exp_t;

  exp_t sb[$];

  rr_grant_arbiter #(.N(4), .HOLD_MAX(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic expect_next(input logic [3:0] g, input logic to);
    exp_t e;
    e.c  = cyc + 1;
    e.g  = g;
    e.to = to;
    sb.push_back(e);
  endtask

  // Apply req for the coming edge; expected outputs after that edge.
  task automatic drive(input logic [3:0] r, input logic [3:0] g, input logic to);
    @(posedge clk);
    #2;
    req = r;
    expect_next(g, to);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},   32'(gnt),       32'd0);
    check({tag, "_valid"}, 32'(gnt_valid), 32'd0);
    check({tag, "_id"},    32'(gnt_id),    32'd0);
    check({tag, "_to"},    32'(timeout),   32'd0);
  endtask

  // Monitor: pop expectations whose cycle has arrived and compare.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].c <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("cycle_tag@%0d", cyc), 32'(e.c), 32'(cyc));
        check($sformatf("gnt@%0d", cyc),       32'(gnt),       32'(e.g));
        check($sformatf("gnt_valid@%0d", cyc), 32'(gnt_valid), 32'(e.g != 4'b0000));
        check($sformatf("gnt_id@%0d", cyc),    32'(gnt_id),    32'(idx_of(e.g)));
        check($sformatf("timeout@%0d", cyc),   32'(timeout),   32'(e.to));
      end
    end
  end

  initial begin
    // Reset held with all requests up.
    #2;
    check_reset_outputs("rst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    expect_next(4'b0001, 1'b0);

    // Rotation 0,1,2,3,0,1: each grantee drops for one cycle after two.
    drive(4'b1111, 4'b0001, 1'b0);
    drive(4'b1110, 4'b0010, 1'b0);
    drive(4'b1111, 4'b0010, 1'b0);
    drive(4'b1101, 4'b0100, 1'b0);
    drive(4'b1111, 4'b0100, 1'b0);
    drive(4'b1011, 4'b1000, 1'b0);
    drive(4'b1111, 4'b1000, 1'b0);
    drive(4'b0111, 4'b0001, 1'b0);
    drive(4'b1111, 4'b0001, 1'b0);
    drive(4'b1110, 4'b0010, 1'b0);

    // Back-to-back handover 1 -> 2.
    drive(4'b0110, 4'b0010, 1'b0);
    drive(4'b0100, 4'b0100, 1'b0);

    // ptr=3: only requester 0 -> fallback to lowest bit, ptr becomes 1.
    drive(4'b0001, 4'b0001, 1'b0);
    drive(4'b1001, 4'b0001, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    // ptr=1 with 1001 pending -> requester 3 wins over 0.
    drive(4'b1001, 4'b1000, 1'b0);
    drive(4'b1001, 4'b1000, 1'b0);
    // ptr wrapped to 0 -> requester 0 preferred over 2.
    drive(4'b0101, 4'b0001, 1'b0);
    drive(4'b0100, 4'b0100, 1'b0);
    drive(4'b0100, 4'b0100, 1'b0);

    // Async reset between edges mid-grant; ptr restarts at 0 so 2 beats 3.
    @(posedge clk);
    #7;
    req   = 4'b1100;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    #1;
    rst_n = 1'b1;
    expect_next(4'b0100, 1'b0);
    drive(4'b1100, 4'b0100, 1'b0);
    drive(4'b1000, 4'b1000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Requester 1 stuck: exactly 8 grant cycles, then revoke to 3.
    drive(4'b1010, 4'b0010, 1'b0);
    for (int i = 0; i < 7; i++) drive(4'b1010, 4'b0010, 1'b0);
    drive(4'b1010, 4'b1000, 1'b1);
    drive(4'b1010, 4'b1000, 1'b0);
    // Requester 1 stays blocked until its req is sampled low.
    drive(4'b0010, 4'b0000, 1'b0);
    drive(4'b0010, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0010, 4'b0010, 1'b0);
`else
    // Without the timeout feature the grant is held indefinitely.
    drive(4'b1010, 4'b0010, 1'b0);
    for (int i = 0; i < 10; i++) drive(4'b1010, 4'b0010, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
`endif

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
